mem_port_arbiter: RTL

- Shares the single core memory port between the instruction-fetch requester (I-port) and the store-buffer/LSU requester (D-port).
- Sits between the fetch stage / store buffer and the external memory interface.
- Captures pulsed requests, grants one outstanding transaction at a time, and routes the response back to its owner.
- Bounds data-side starvation of fetch and supports a fetch flush that cancels or swallows instruction traffic.

---
 rtl/mem_port_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Function : Shares one memory port between fetch (I) and LSU (D) requesters.
//            Optional same-cycle request bypass: define MEM_ARB_BYPASS_EN.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_valid,
  input  logic [XLEN-1:0]   imem_addr,
  input  logic              imem_flush,
  output logic [XLEN-1:0]   imem_rdata,
  output logic              imem_ready,
  input  logic              dmem_valid,
  input  logic              dmem_instr,
  input  logic [XLEN-1:0]   dmem_addr,
  input  logic [XLEN-1:0]   dmem_wdata,
  input  logic [XLEN/8-1:0] dmem_wstrb,
  output logic [XLEN-1:0]   dmem_rdata,
  output logic              dmem_ready,
  output logic              mem_valid,
  output logic              mem_instr,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready,
  output logic              err_overrun
);

  localparam int         c_SW      = XLEN / 8;
  localparam logic [3:0] c_RUN_MAX = 4'(MAX_DATA_RUN);
  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_BUSY_I  = 2'd1;
  localparam logic [1:0] c_BUSY_D  = 2'd2;

  logic [1:0]      r_state, w_state_nxt;
  logic            r_pend_i, r_pend_d, r_swallow, r_err_overrun;
  logic [3:0]      r_run_cnt;
  logic [XLEN-1:0] r_i_addr, r_d_addr, r_d_wdata;
  logic [c_SW-1:0] r_d_wstrb;
  logic            r_d_instr;
  logic [XLEN-1:0] r_mem_addr, r_mem_wdata;
  logic [c_SW-1:0] r_mem_wstrb;
  logic            r_mem_instr;
  logic [XLEN-1:0] r_imem_rdata, r_dmem_rdata;

  logic w_idle, w_busy_i, w_busy_d;
  logic w_i_outstanding, w_d_outstanding;
  logic w_i_cap, w_d_cap, w_overrun;
  logic w_gnt_i, w_gnt_d, w_byp_i, w_byp_d, w_sel_i, w_sel_d;

  assign w_idle   = (r_state == c_IDLE);
  assign w_busy_i = (r_state == c_BUSY_I);
  assign w_busy_d = (r_state == c_BUSY_D);

  // A flush retires older I traffic, and a completing response frees its
  // port, so a new valid in either of those cycles is accepted.
  assign w_i_outstanding = ~imem_flush & (r_pend_i | (w_busy_i & ~r_swallow & ~mem_ready));
  assign w_d_outstanding = r_pend_d | (w_busy_d & ~mem_ready);
  assign w_overrun       = (imem_valid & w_i_outstanding) | (dmem_valid & w_d_outstanding);

  assign w_gnt_d = w_idle & r_pend_d & (~r_pend_i | (r_run_cnt != c_RUN_MAX));
  assign w_gnt_i = w_idle & r_pend_i & ~w_gnt_d;

`ifdef MEM_ARB_BYPASS_EN
  logic w_byp_ok;
  assign w_byp_ok = w_idle & ~r_pend_i & ~r_pend_d;
  assign w_byp_d  = w_byp_ok & dmem_valid;
  assign w_byp_i  = w_byp_ok & imem_valid & ~dmem_valid;
`else
  assign w_byp_d  = 1'b0;
  assign w_byp_i  = 1'b0;
`endif

  assign w_sel_d = w_gnt_d | w_byp_d;
  assign w_sel_i = w_gnt_i | w_byp_i;
  assign w_i_cap = imem_valid & ~w_i_outstanding & ~w_byp_i;
  assign w_d_cap = dmem_valid & ~w_d_outstanding & ~w_byp_d;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_sel_d)      w_state_nxt = c_BUSY_D;
        else if (w_sel_i) w_state_nxt = c_BUSY_I;
      end
      c_BUSY_I, c_BUSY_D: begin
        if (mem_ready) w_state_nxt = c_IDLE;
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Output logic: the grant cycle drives the chosen payload directly, later
  // cycles replay the copy latched at grant.
  always_comb begin
    mem_valid = w_sel_i | w_sel_d;
    mem_instr = r_mem_instr;
    mem_addr  = r_mem_addr;
    mem_wdata = r_mem_wdata;
    mem_wstrb = r_mem_wstrb;
    if (w_gnt_d) begin
      mem_instr = r_d_instr;
      mem_addr  = r_d_addr;
      mem_wdata = r_d_wdata;
      mem_wstrb = r_d_wstrb;
    end else if (w_byp_d) begin
      mem_instr = dmem_instr;
      mem_addr  = dmem_addr;
      mem_wdata = dmem_wdata;
      mem_wstrb = dmem_wstrb;
    end else if (w_sel_i) begin
      mem_instr = 1'b1;
      mem_addr  = w_byp_i ? imem_addr : r_i_addr;
      mem_wdata = '0;
      mem_wstrb = '0;
    end
    imem_ready = mem_ready & w_busy_i & ~r_swallow & ~imem_flush;
    dmem_ready = mem_ready & w_busy_d;
    imem_rdata = imem_ready ? mem_rdata : r_imem_rdata;
    dmem_rdata = dmem_ready ? mem_rdata : r_dmem_rdata;
  end

  // Pending buffers, arbitration history and held transaction payload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_i      <= 1'b0;
      r_pend_d      <= 1'b0;
      r_swallow     <= 1'b0;
      r_err_overrun <= 1'b0;
      r_run_cnt     <= '0;
      r_i_addr      <= '0;
      r_d_addr      <= '0;
      r_d_wdata     <= '0;
      r_d_wstrb     <= '0;
      r_d_instr     <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_wstrb   <= '0;
      r_mem_instr   <= 1'b0;
      r_imem_rdata  <= '0;
      r_dmem_rdata  <= '0;
    end else begin
      if (w_i_cap) begin
        r_pend_i <= 1'b1;
        r_i_addr <= imem_addr;
      end else if (imem_flush || w_gnt_i) begin
        r_pend_i <= 1'b0;
      end

      if (w_d_cap) begin
        r_pend_d  <= 1'b1;
        r_d_addr  <= dmem_addr;
        r_d_wdata <= dmem_wdata;
        r_d_wstrb <= dmem_wstrb;
        r_d_instr <= dmem_instr;
      end else if (w_gnt_d) begin
        r_pend_d <= 1'b0;
      end

      // A flush landing on the grant cycle still swallows that transaction.
      if (w_busy_i && mem_ready)                  r_swallow <= 1'b0;
      else if (imem_flush && (w_busy_i || w_gnt_i)) r_swallow <= 1'b1;

      if (w_overrun) r_err_overrun <= 1'b1;

      if (w_gnt_i || !r_pend_i)                  r_run_cnt <= '0;
      else if (w_gnt_d && r_run_cnt != c_RUN_MAX) r_run_cnt <= r_run_cnt + 4'd1;

      if (mem_valid) begin
        r_mem_addr  <= mem_addr;
        r_mem_wdata <= mem_wdata;
        r_mem_wstrb <= mem_wstrb;
        r_mem_instr <= mem_instr;
      end

      if (imem_ready) r_imem_rdata <= mem_rdata;
      if (dmem_ready) r_dmem_rdata <= mem_rdata;
    end
  end

  assign err_overrun = r_err_overrun;

endmodule
`default_nettype wire
